// File: rtl/window_shift_buffer_if.sv
// Write/shift/read bus of the window shift buffer.
// The controller drives it through the master modport; the array sits on the slave modport.
interface window_shift_buffer_if #(
   parameter int DATA_W   = 8,
   parameter int ROWS     = 8,
   parameter int COLS     = 8,
   parameter int WR_ELEMS = 4,
   parameter int ADDR_W   = $clog2(ROWS*COLS),
   parameter int CNT_W    = $clog2(2*COLS+1)
);
   logic                       clear;
   logic                       wr_valid;
   logic                       wr_ready;
   logic [ADDR_W-1:0]          wr_addr;
   logic [WR_ELEMS*DATA_W-1:0] wr_data;
   logic                       shift_en;
   logic [1:0]                 shift_mode;
   logic [ADDR_W-1:0]          rd_addr;
   logic [DATA_W-1:0]          rd_data;
   logic                       full;
   logic                       empty;
   logic [CNT_W-1:0]           shift_cnt;

   modport master (
      output clear, wr_valid, wr_addr, wr_data, shift_en, shift_mode, rd_addr,
      input  wr_ready, rd_data, full, empty, shift_cnt
   );

   modport slave (
      input  clear, wr_valid, wr_addr, wr_data, shift_en, shift_mode, rd_addr,
      output wr_ready, rd_data, full, empty, shift_cnt
   );
endinterface

// File: rtl/window_shift_buffer.sv
// ROWS x COLS element array loaded by multi-element word writes, then drained or
// recirculated by whole-array column shifts (zero-fill, rotate, half-cascade).
module window_shift_buffer #(
   parameter int DATA_W   = 8,
   parameter int ROWS     = 8,
   parameter int COLS     = 8,
   parameter int WR_ELEMS = 4,
   parameter int ADDR_W   = $clog2(ROWS*COLS),
   parameter int CNT_W    = $clog2(2*COLS+1)
) (
   input  logic                 clk,
   input  logic                 rst,
   window_shift_buffer_if.slave bus
);
   localparam int N      = ROWS*COLS;
   localparam int WORDS  = N/WR_ELEMS;
   localparam int WCNT_W = $clog2(WORDS+1);
   localparam int HALF   = ROWS/2;
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(2*COLS);
   localparam logic [CNT_W-1:0]  CNT_ROW   = CNT_W'(COLS);
   localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(WORDS-1);

   logic [DATA_W-1:0] r_mem       [N];
   logic [DATA_W-1:0] w_shift_mem [N];
   logic [ADDR_W-1:0] w_wr_idx    [WR_ELEMS];
   logic [ADDR_W:0]   w_sum;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_full;
   logic              r_empty;
   logic [CNT_W-1:0]  r_shift_cnt;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic [WCNT_W-1:0] r_word_cnt;
   logic              w_wr_fire;
   logic              w_shift_fire;
   logic              w_drain;

   assign w_wr_fire    = bus.wr_valid && !r_full;
   assign w_shift_fire = bus.shift_en && r_full && (bus.shift_mode != 2'd3);
   assign w_cnt_inc    = (r_shift_cnt >= CNT_MAX) ? CNT_MAX : (r_shift_cnt + CNT_W'(1));
   // Drain threshold follows the mode of the shift being performed right now.
   assign w_drain      = w_shift_fire &&
                         (((bus.shift_mode == 2'd0) && (w_cnt_inc >= CNT_ROW)) ||
                          ((bus.shift_mode == 2'd2) && (w_cnt_inc >= CNT_MAX)));

   assign bus.wr_ready  = !r_full;
   assign bus.rd_data   = r_rd_data;
   assign bus.full      = r_full;
   assign bus.empty     = r_empty;
   assign bus.shift_cnt = r_shift_cnt;

   // Word element addresses, wrapping modulo the array size.
   always_comb begin
      w_sum = '0;
      for (int k = 0; k < WR_ELEMS; k++) begin
         w_sum = {1'b0, bus.wr_addr} + (ADDR_W+1)'(k);
         if (w_sum >= (ADDR_W+1)'(N)) begin
            w_wr_idx[k] = ADDR_W'(w_sum - (ADDR_W+1)'(N));
         end else begin
            w_wr_idx[k] = w_sum[ADDR_W-1:0];
         end
      end
   end

   // Shifted image of the whole array, built from pre-shift contents.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         w_shift_mem[i] = '0;
      end
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS-1; c++) begin
            w_shift_mem[r*COLS+c] = r_mem[r*COLS+c+1];
         end
         case (bus.shift_mode)
            2'd1: w_shift_mem[r*COLS+COLS-1] = r_mem[r*COLS];
            2'd2: begin
               if (r < HALF) begin
                  w_shift_mem[r*COLS+COLS-1] = r_mem[((r+HALF)%ROWS)*COLS];
               end else begin
                  w_shift_mem[r*COLS+COLS-1] = '0;
               end
            end
            default: w_shift_mem[r*COLS+COLS-1] = '0;
         endcase
      end
   end

   // Array storage: clear, then shift, then word write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) r_mem[i] <= '0;
      end else if (bus.clear) begin
         for (int i = 0; i < N; i++) r_mem[i] <= '0;
      end else if (w_shift_fire) begin
         for (int i = 0; i < N; i++) r_mem[i] <= w_shift_mem[i];
      end else if (w_wr_fire) begin
         for (int k = 0; k < WR_ELEMS; k++) begin
            r_mem[w_wr_idx[k]] <= bus.wr_data[(WR_ELEMS-1-k)*DATA_W +: DATA_W];
         end
      end
   end

   // Registered read port; sees contents before any same-edge update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_data <= '0;
      end else if (bus.clear) begin
         r_rd_data <= '0;
      end else if (int'(bus.rd_addr) < N) begin
         r_rd_data <= r_mem[bus.rd_addr];
      end else begin
         r_rd_data <= '0;
      end
   end

   // Occupancy, fill/drain flags and shift counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_word_cnt  <= '0;
         r_shift_cnt <= '0;
         r_full      <= 1'b0;
         r_empty     <= 1'b1;
      end else if (bus.clear) begin
         r_word_cnt  <= '0;
         r_shift_cnt <= '0;
         r_full      <= 1'b0;
         r_empty     <= 1'b1;
      end else if (w_wr_fire) begin
         r_empty <= 1'b0;
         if (r_word_cnt == WORD_LAST) begin
            r_word_cnt  <= r_word_cnt + WCNT_W'(1);
            r_full      <= 1'b1;
            r_shift_cnt <= '0;
         end else begin
            r_word_cnt <= r_word_cnt + WCNT_W'(1);
         end
      end else if (w_shift_fire) begin
         if (w_drain) begin
            r_word_cnt  <= '0;
            r_shift_cnt <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
         end else begin
            r_shift_cnt <= w_cnt_inc;
         end
      end else begin
         r_shift_cnt <= r_shift_cnt;
      end
   end
endmodule

// File: tb/tb_window_shift_buffer.sv
// Directed scoreboard bench for window_shift_buffer: stimulus queues expectations,
// a negedge monitor pops and compares read data and status.
module tb_window_shift_buffer;
   localparam int ADDR_W = 6;
   localparam int CNT_W  = 5;

   typedef struct {
      string      nm;
      logic [7:0] v;
   } rd_item_t;

   typedef struct {
      string            nm;
      logic             f;
      logic             e;
      logic             r;
      logic [CNT_W-1:0] c;
   } st_item_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rd_req = 1'b0;
   logic rd_req_d = 1'b0;
   logic st_req = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   rd_item_t rd_q[$];
   st_item_t st_q[$];

   window_shift_buffer_if bus ();

   window_shift_buffer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rd_req_d <= rd_req;

   task automatic cmp(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   // Monitor: compares whatever the DUT presents against the queued expectations.
   initial begin
      rd_item_t ri;
      st_item_t si;
      forever begin
         @(negedge clk);
         if (rd_req_d) begin
            if (rd_q.size() == 0) begin
               cmp("rd_queue_underflow", 1, 0);
            end else begin
               ri = rd_q.pop_front();
               cmp(ri.nm, int'(bus.rd_data), int'(ri.v));
            end
         end
         if (st_req) begin
            if (st_q.size() == 0) begin
               cmp("st_queue_underflow", 1, 0);
            end else begin
               si = st_q.pop_front();
               cmp({si.nm, ".full"},      int'(bus.full),      int'(si.f));
               cmp({si.nm, ".empty"},     int'(bus.empty),     int'(si.e));
               cmp({si.nm, ".wr_ready"},  int'(bus.wr_ready),  int'(si.r));
               cmp({si.nm, ".shift_cnt"}, int'(bus.shift_cnt), int'(si.c));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] word_of(input int k);
      logic [7:0] b;
      logic [31:0] w;
      w = '0;
      for (int j = 0; j < 4; j++) begin
         b = 8'(4*k + j);
         w[(3-j)*8 +: 8] = b;
      end
      return w;
   endfunction

   task automatic do_write(input int addr, input logic [31:0] data);
      bus.wr_addr  = ADDR_W'(addr);
      bus.wr_data  = data;
      bus.wr_valid = 1'b1;
      tick();
      bus.wr_valid = 1'b0;
   endtask

   task automatic fill(input int k0, input int k1);
      for (int k = k0; k <= k1; k++) do_write(4*k, word_of(k));
   endtask

   task automatic do_shift(input logic [1:0] m, input int n);
      bus.shift_mode = m;
      bus.shift_en   = 1'b1;
      repeat (n) tick();
      bus.shift_en   = 1'b0;
   endtask

   task automatic exp_rd(input int addr, input logic [7:0] v, input string nm);
      rd_q.push_back('{nm, v});
      bus.rd_addr = ADDR_W'(addr);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
   endtask

   task automatic exp_st(input logic f, input logic e, input logic r, input int c, input string nm);
      st_q.push_back('{nm, f, e, r, CNT_W'(c)});
      st_req = 1'b1;
      @(negedge clk);
      #1;
      st_req = 1'b0;
   endtask

   initial begin
      bus.clear = 1'b0;
      bus.wr_valid = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.shift_en = 1'b0;
      bus.shift_mode = 2'd0;
      bus.rd_addr = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      exp_st(1'b0, 1'b1, 1'b1, 0, "reset");
      exp_rd(0, 8'd0, "reset_rd0");

      // Fill
      fill(0, 14);
      exp_st(1'b0, 1'b0, 1'b1, 0, "fill15");
      fill(15, 15);
      exp_st(1'b1, 1'b0, 1'b0, 0, "fill16");
      exp_rd(9, 8'd9, "fill_rd9");

      // Zero-fill shifts
      do_shift(2'd0, 1);
      exp_st(1'b1, 1'b0, 1'b0, 1, "zf1");
      exp_rd(0, 8'd1, "zf1_e0");
      exp_rd(7, 8'd0, "zf1_e7");
      exp_rd(8, 8'd9, "zf1_e8");
      exp_rd(15, 8'd0, "zf1_e15");
      do_shift(2'd0, 7);
      exp_st(1'b0, 1'b1, 1'b1, 0, "zf_drain");
      for (int i = 0; i < 64; i++) exp_rd(i, 8'd0, $sformatf("zf_zero_e%0d", i));

      // Rotate
      fill(0, 15);
      do_shift(2'd1, 1);
      exp_rd(7, 8'd0, "rot1_e7");
      exp_rd(15, 8'd8, "rot1_e15");
      exp_st(1'b1, 1'b0, 1'b0, 1, "rot1");
      do_shift(2'd1, 19);
      exp_st(1'b1, 1'b0, 1'b0, 16, "rot20_sat");
      exp_rd(0, 8'd4, "rot20_e0");

      // Clear together with a write and a read of a non-zero element
      rd_q.push_back('{"clear_rd9", 8'd0});
      bus.rd_addr = ADDR_W'(9);
      rd_req = 1'b1;
      bus.clear = 1'b1;
      bus.wr_addr = '0;
      bus.wr_data = 32'h11223344;
      bus.wr_valid = 1'b1;
      tick();
      rd_req = 1'b0;
      bus.clear = 1'b0;
      bus.wr_valid = 1'b0;
      exp_st(1'b0, 1'b1, 1'b1, 0, "clear");
      exp_rd(0, 8'd0, "clear_wr_dropped");

      // Cascade
      fill(0, 15);
      do_shift(2'd2, 1);
      exp_rd(7, 8'd32, "cas1_e7");
      exp_rd(39, 8'd0, "cas1_e39");
      exp_rd(31, 8'd56, "cas1_e31");
      exp_st(1'b1, 1'b0, 1'b0, 1, "cas1");
      do_shift(2'd2, 14);
      exp_st(1'b1, 1'b0, 1'b0, 15, "cas15");
      do_shift(2'd2, 1);
      exp_st(1'b0, 1'b1, 1'b1, 0, "cas16_drain");

      // Wrapping write, ignored shifts
      do_write(62, 32'hAABBCCDD);
      exp_rd(62, 8'hAA, "wrap_e62");
      exp_rd(63, 8'hBB, "wrap_e63");
      exp_rd(0, 8'hCC, "wrap_e0");
      exp_rd(1, 8'hDD, "wrap_e1");
      exp_st(1'b0, 1'b0, 1'b1, 0, "wrap_st");
      do_shift(2'd1, 2);
      exp_st(1'b0, 1'b0, 1'b1, 0, "noshift_notfull");
      exp_rd(0, 8'hCC, "noshift_notfull_e0");
      fill(1, 15);
      exp_st(1'b1, 1'b0, 1'b0, 0, "refill_full");
      do_shift(2'd3, 3);
      exp_st(1'b1, 1'b0, 1'b0, 0, "hold_mode");
      exp_rd(0, 8'hCC, "hold_e0");
      do_shift(2'd0, 1);
      exp_rd(0, 8'hDD, "after_hold_e0");
      exp_st(1'b1, 1'b0, 1'b0, 1, "after_hold");

      // Asynchronous reset mid-cycle
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      fill(0, 4);
      exp_rd(17, 8'd17, "pre_rst_rd17");
      tick();
      cmp("pre_rst_rd_hold", int'(bus.rd_data), 17);
      #3;
      rst = 1'b1;
      #1;
      cmp("async_rst_rd_data", int'(bus.rd_data), 0);
      cmp("async_rst_empty", int'(bus.empty), 1);
      @(negedge clk);
      rst = 1'b0;
      tick();
      fill(0, 14);
      exp_st(1'b0, 1'b0, 1'b1, 0, "post_rst_15");
      fill(15, 15);
      exp_st(1'b1, 1'b0, 1'b0, 0, "post_rst_16");

      repeat (3) tick();
      cmp("scoreboard_drained", rd_q.size() + st_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
